// File: rtl/irq_controller_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : irq_controller_pkg                                       |
// | Description : Shared types and constants for the interrupt controller: |
// |               FSM state encoding, vector id width, default sizing.     |
// | Ports       : none (package)                                           |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package irq_controller_pkg;

  // vec_id is always presented as 3 bits, zero-extended from the winner index.
  localparam int unsigned C_VEC_W               = 3;
  localparam int unsigned C_N_SRC_DEFAULT       = 4;
  localparam int unsigned C_SYNC_STAGES_DEFAULT = 2;

  // Encoding 2'd3 is unused; the FSM decodes it exactly like ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage
`default_nettype wire

// File: rtl/irq_controller_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : irq_controller_if                                        |
// | Description : Bundle between peripherals/core and the interrupt        |
// |               controller.                                              |
// | Ports       : irq_src, mask_we, mask_wdata, cpu_int_ack, cpu_rti       |
// |               (towards controller); cpu_int, vec_id, pending, busy     |
// |               (from controller).                                       |
// |               master = peripherals/core side, slave = controller side. |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
interface irq_controller_if #(
  parameter int N_SRC = 4
);
  import irq_controller_pkg::*;

  logic [N_SRC-1:0]   irq_src;
  logic               mask_we;
  logic [N_SRC-1:0]   mask_wdata;
  logic               cpu_int_ack;
  logic               cpu_rti;
  logic               cpu_int;
  logic [C_VEC_W-1:0] vec_id;
  logic [N_SRC-1:0]   pending;
  logic               busy;

  modport master (
    output irq_src, mask_we, mask_wdata, cpu_int_ack, cpu_rti,
    input  cpu_int, vec_id, pending, busy
  );

  modport slave (
    input  irq_src, mask_we, mask_wdata, cpu_int_ack, cpu_rti,
    output cpu_int, vec_id, pending, busy
  );

endinterface
`default_nettype wire

// File: rtl/irq_controller_sync_edge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : irq_controller_sync_edge                                 |
// | Description : Synchronises one asynchronous IRQ line through           |
// |               SYNC_STAGES flops and emits a one-cycle pulse on each    |
// |               synchronised rising edge.                                |
// | Ports       : clk, rst_n (async, active-low), i_async (raw line),      |
// |               o_edge (1-cycle rising-edge pulse)                       |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module irq_controller_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Pulse is combinational off the last stage so the pending latch can
  // capture it on the very next edge.
  assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : irq_controller                                           |
// | Description : Gathers peripheral IRQ lines, latches rising edges into  |
// |               a sticky pending register, masks and prioritises them    |
// |               (lowest index wins) and holds a single int request to    |
// |               the core until ISR entry is acknowledged. No further     |
// |               request is raised until the core retires RTI.            |
// | Ports       : clk, rst_n (async, active-low),                          |
// |               bus (irq_controller_if.slave): irq_src, mask_we,         |
// |               mask_wdata, cpu_int_ack, cpu_rti in; cpu_int, vec_id,    |
// |               pending, busy out.                                       |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int N_SRC       = C_N_SRC_DEFAULT,
  parameter int SYNC_STAGES = C_SYNC_STAGES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  irq_controller_if.slave      bus
);

  logic [N_SRC-1:0]   w_edge;
  logic [N_SRC-1:0]   w_eligible;
  logic [N_SRC-1:0]   w_clr;
  logic [N_SRC-1:0]   r_pending;
  logic [N_SRC-1:0]   r_mask;
  logic [C_VEC_W-1:0] r_vec_id;
  logic [C_VEC_W-1:0] w_vec_nxt;
  logic               w_ack_take;
  irq_state_e         r_state;
  irq_state_e         w_state_nxt;

  // Fixed priority: lowest set index wins.
  function automatic logic [C_VEC_W-1:0] f_winner(input logic [N_SRC-1:0] req);
    f_winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) f_winner = C_VEC_W'(i);
    end
  endfunction

  // ---------------------------------------------------------------- inputs
  generate
    for (genvar g = 0; g < N_SRC; g++) begin : g_src
      irq_controller_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (bus.irq_src[g]),
        .o_edge  (w_edge[g])
      );
    end
  endgenerate

  // ------------------------------------------------------- mask / pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '1;
    end else if (bus.mask_we) begin
      r_mask <= bus.mask_wdata;
    end
  end

  // Only the serviced source is cleared, and only on an accepted ack.
  assign w_clr = w_ack_take ? (N_SRC'(1) << r_vec_id) : '0;

  // Set wins over clear: an edge arriving with the ack re-pends the source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_edge;
    end
  end

  // Masked sources still latch; they are only kept out of arbitration.
  assign w_eligible = r_pending & r_mask;

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_vec_id <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_vec_id <= w_vec_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec_id;
    w_ack_take  = 1'b0;
    case (r_state)
      ST_ASSERT: begin
        // Selection is frozen here; rti is ignored even alongside an ack.
        if (bus.cpu_int_ack) begin
          w_ack_take  = 1'b1;
          w_state_nxt = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (bus.cpu_rti) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        // ST_IDLE and the unused encoding behave identically.
        w_state_nxt = ST_IDLE;
        if (|w_eligible) begin
          w_state_nxt = ST_ASSERT;
          w_vec_nxt   = f_winner(w_eligible);
        end
      end
    endcase
  end

  // --------------------------------------------------------------- outputs
  assign bus.cpu_int = (r_state == ST_ASSERT);
  assign bus.busy    = (r_state == ST_ASSERT) || (r_state == ST_SERVICE);
  assign bus.vec_id  = r_vec_id;
  assign bus.pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_irq_controller                                        |
// | Description : Self-checking bench for irq_controller. Stimulus pushes  |
// |               expected interrupt assertions and status snapshots into  |
// |               queues; a monitor pops and compares them.                |
// | Ports       : none                                                     |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_irq_controller;

  localparam int C_N_SRC = 4;
  localparam int C_SYNC  = 2;

  typedef struct {
    string      name;
    logic       cint;
    logic       busy;
    logic [3:0] pend;
  } st_exp_t;

  typedef struct {
    logic [2:0] vec;
    int         cyc;
  } int_exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  bit   done = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  st_exp_t  st_q[$];
  int_exp_t int_q[$];

  irq_controller_if #(.N_SRC(C_N_SRC)) bus ();

  irq_controller #(
    .N_SRC       (C_N_SRC),
    .SYNC_STAGES (C_SYNC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------------ helpers
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic ci, input logic bz, input logic [3:0] pd);
    st_q.push_back('{name: nm, cint: ci, busy: bz, pend: pd});
  endtask

  task automatic exp_int(input logic [2:0] v, input int c);
    int_q.push_back('{vec: v, cyc: c});
  endtask

  task automatic pulse_ack();
    bus.cpu_int_ack = 1'b1;
    tick();
    bus.cpu_int_ack = 1'b0;
  endtask

  task automatic pulse_rti();
    bus.cpu_rti = 1'b1;
    tick();
    bus.cpu_rti = 1'b0;
  endtask

  // ---------------------------------------------------------- stimulus
  initial begin
    rst_n           = 1'b0;
    bus.irq_src     = 4'hF;
    bus.mask_we     = 1'b0;
    bus.mask_wdata  = 4'h0;
    bus.cpu_int_ack = 1'b0;
    bus.cpu_rti     = 1'b0;

    // Reset with all sources high
    tick(3);
    chk("reset", 1'b0, 1'b0, 4'b0000);
    tick();
    bus.irq_src = 4'h0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk("post_reset", 1'b0, 1'b0, 4'b0000);

    // Single IRQ on source 2: latency SYNC+2, hold without ack
    tick();
    bus.irq_src[2] = 1'b1;
    exp_int(3'd2, cyc + C_SYNC + 2);
    tick(2);
    bus.irq_src[2] = 1'b0;
    tick(2);
    chk("single_assert", 1'b1, 1'b1, 4'b0100);
    pulse_rti();
    tick(4);
    chk("hold_no_ack", 1'b1, 1'b1, 4'b0100);
    pulse_ack();
    chk("single_ack", 1'b0, 1'b1, 4'b0000);
    tick(2);
    pulse_ack();
    chk("ack_in_service", 1'b0, 1'b1, 4'b0000);
    pulse_rti();
    chk("rti_to_idle", 1'b0, 1'b0, 4'b0000);

    // Priority: src3 and src1 together
    tick(2);
    bus.irq_src = 4'b1010;
    exp_int(3'd1, cyc + 4);
    tick(4);
    bus.irq_src = 4'b0000;
    chk("prio_assert", 1'b1, 1'b1, 4'b1010);
    tick();
    bus.cpu_int_ack = 1'b1;
    bus.cpu_rti     = 1'b1;
    tick();
    bus.cpu_int_ack = 1'b0;
    bus.cpu_rti     = 1'b0;
    chk("ack_rti_same", 1'b0, 1'b1, 4'b1000);
    tick(2);
    bus.cpu_rti = 1'b1;
    exp_int(3'd3, cyc + 2);
    tick();
    bus.cpu_rti = 1'b0;
    chk("rti_idle", 1'b0, 1'b0, 4'b1000);
    tick();
    chk("prio_reassert", 1'b1, 1'b1, 4'b1000);
    pulse_ack();
    chk("prio_ack3", 1'b0, 1'b1, 4'b0000);
    pulse_rti();

    // Mask: src0 masked still pends, unmask asserts
    tick(2);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 4'b1110;
    tick();
    bus.mask_we    = 1'b0;
    bus.irq_src[0] = 1'b1;
    tick(2);
    bus.irq_src[0] = 1'b0;
    tick(4);
    chk("masked_pending", 1'b0, 1'b0, 4'b0001);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 4'hF;
    exp_int(3'd0, cyc + 2);
    tick();
    bus.mask_we = 1'b0;
    tick();
    chk("unmask_assert", 1'b1, 1'b1, 4'b0001);
    pulse_ack();
    pulse_rti();

    // No nesting: edge in SERVICE waits for rti
    tick(2);
    bus.irq_src[1] = 1'b1;
    exp_int(3'd1, cyc + 4);
    tick(2);
    bus.irq_src[1] = 1'b0;
    tick(2);
    pulse_ack();
    bus.irq_src[0] = 1'b1;
    tick(2);
    bus.irq_src[0] = 1'b0;
    tick(4);
    chk("no_nesting", 1'b0, 1'b1, 4'b0001);
    bus.cpu_rti = 1'b1;
    exp_int(3'd0, cyc + 2);
    tick();
    bus.cpu_rti = 1'b0;
    tick();
    chk("after_rti_assert", 1'b1, 1'b1, 4'b0001);
    pulse_ack();
    pulse_rti();

    // Set wins over clear: new src2 edge lands with the ack of src2
    tick(2);
    bus.irq_src[2] = 1'b1;
    exp_int(3'd2, cyc + 4);
    tick(2);
    bus.irq_src[2] = 1'b0;
    tick(3);
    bus.irq_src[2] = 1'b1;
    tick(2);
    bus.cpu_int_ack = 1'b1;
    tick();
    bus.cpu_int_ack = 1'b0;
    bus.irq_src[2]  = 1'b0;
    chk("set_wins", 1'b0, 1'b1, 4'b0100);
    bus.cpu_rti = 1'b1;
    exp_int(3'd2, cyc + 2);
    tick();
    bus.cpu_rti = 1'b0;
    tick();
    pulse_ack();
    pulse_rti();

    // Reset in the middle of ASSERT acts immediately
    tick(2);
    bus.irq_src[3] = 1'b1;
    exp_int(3'd3, cyc + 4);
    tick(2);
    bus.irq_src[3] = 1'b0;
    tick(2);
    chk("pre_reset_assert", 1'b1, 1'b1, 4'b1000);
    tick();
    #2;
    rst_n = 1'b0;
    chk("async_reset", 1'b0, 1'b0, 4'b0000);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("after_reset_idle", 1'b0, 1'b0, 4'b0000);

    tick(10);
    done = 1'b1;
  end

  // ----------------------------------------------------------- monitor
  initial begin : monitor
    logic     prev_int;
    st_exp_t  s;
    int_exp_t e;
    prev_int = 1'b0;
    forever begin
      @(negedge clk);
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        n_checks++;
        if (bus.cpu_int === s.cint && bus.busy === s.busy && bus.pending === s.pend)
          n_pass++;
        else
          $display("FAIL %s: got cpu_int=%b busy=%b pending=%b, expected cpu_int=%b busy=%b pending=%b",
                   s.name, bus.cpu_int, bus.busy, bus.pending, s.cint, s.busy, s.pend);
      end
      if (bus.cpu_int === 1'b1 && prev_int === 1'b0) begin
        n_checks++;
        if (int_q.size() == 0) begin
          $display("FAIL unexpected_int: cpu_int rose at cycle %0d vec_id=%0d, none expected",
                   cyc, bus.vec_id);
        end else begin
          e = int_q.pop_front();
          if (bus.vec_id === e.vec && cyc == e.cyc)
            n_pass++;
          else
            $display("FAIL int_assert: got vec_id=%0d at cycle %0d, expected vec_id=%0d at cycle %0d",
                     bus.vec_id, cyc, e.vec, e.cyc);
        end
      end
      prev_int = bus.cpu_int;
      if (done) begin
        while (int_q.size() > 0) begin
          e = int_q.pop_front();
          n_checks++;
          $display("FAIL missing_int: got no assertion, expected vec_id=%0d at cycle %0d",
                   e.vec, e.cyc);
        end
        while (st_q.size() > 0) begin
          s = st_q.pop_front();
          n_checks++;
          $display("FAIL %s: got no sample, expected pending=%b", s.name, s.pend);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
    end
  end

endmodule
`default_nettype wire
